uart_signal_decoder: RTL
========================

UART_SIGNAL_DECODER -- requirements
Module: uart_signal_decoder

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, sets buffer address width (32-byte buffer).
REQ-002 Parameter TIMEOUT_CYCLES, default 100000, sets the inter-byte timeout in clock cycles.
REQ-003 clock  input  1  system clock; all logic SHALL be posedge clock.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  high when the Client holds control; low forces Idle.
REQ-006 rx_byte  input  8  byte from the UART receiver; valid when rx_complete is high.
REQ-007 rx_complete  input  1  one-cycle active-high pulse per received byte.
REQ-008 key_code  output  8  last captured key code.
REQ-009 key_valid  output  1  one-cycle pulse when key_code updates.
REQ-010 buff_wr  output  1  active-low one-cycle buffer write strobe.
REQ-011 buff_addr  output  ADDR_WIDTH  buffer write address.
REQ-012 buff_data  output  8  buffer write data.
REQ-013 stream_active  output  1  high while in Stream state.
REQ-014 stream_done  output  1  one-cycle pulse on stream end (EOS or timeout).
REQ-015 byte_count  output  ADDR_WIDTH+1  bytes stored in the current or last stream (0..32).
REQ-016 overflow  output  1  sticky; set when a stream byte is dropped because the buffer is full.
REQ-017 proto_err  output  1  one-cycle pulse on an unexpected byte or a timeout.

Function
REQ-018 FSM states SHALL be SDIdle, SDKeyWait and SDStream.
REQ-019 SDIdle: rx_byte==KEY_SIGNAL -> SDKeyWait; ==BOS_SIGNAL -> SDStream; any other byte -> proto_err pulse, stay in SDIdle.
REQ-020 BOS acceptance: buff_addr<=0, byte_count<=0 and overflow<=0, effective on the cycle after the rx_complete.
REQ-021 SDKeyWait: on the next rx_complete, key_code<=rx_byte, key_valid pulses on the following cycle (latency 1), then -> SDIdle.
REQ-022 SDStream: rx_byte==EOS_SIGNAL -> stream_done pulse, -> SDIdle; the EOS byte is not stored.
REQ-023 SDStream, any other byte with byte_count<32: buff_data<=rx_byte, buff_wr low for exactly one cycle (the cycle after rx_complete) at the current buff_addr.
REQ-024 After each write, buff_addr and byte_count SHALL increment on the cycle after buff_wr is low.
REQ-025 Full condition is byte_count==32; buff_addr wraps to 0 at that point, but no further write SHALL occur.
REQ-026 SDStream, data byte with byte_count==32: drop the byte, set overflow, keep buff_wr high, remain in SDStream.
REQ-027 Escaping is not supported: a data byte equal to EOS_SIGNAL terminates the stream.
REQ-028 Timeout counter: resets on every rx_complete; counts only in SDKeyWait and SDStream.
REQ-029 Timeout on reaching TIMEOUT_CYCLES: proto_err pulse, -> SDIdle; in SDStream, stream_done also pulses and byte_count is retained.
REQ-030 enable low in any state: -> SDIdle next cycle, no strobes, the rx byte in the same cycle is ignored, and key_code, byte_count and overflow are retained.
REQ-031 rx_complete and timeout expiry in the same cycle: rx_complete wins, the timeout is ignored.
REQ-032 stream_active SHALL be a registered decode of state==SDStream.

Reset
REQ-033 reset low: state=SDIdle, key_code=0, key_valid=0, buff_wr=1, buff_addr=0, buff_data=0, stream_active=0, stream_done=0, byte_count=0, overflow=0, proto_err=0, timeout counter=0.
REQ-034 Reset mid-stream SHALL abort without a stream_done pulse; reset takes priority over all other inputs.

Structure
REQ-035 Shared package SHALL hold the decoder state enum and KEY_SIGNAL=8'h01, BOS_SIGNAL=8'h02, EOS_SIGNAL=8'h03, alongside the existing UART state enum and signal constants.
REQ-036 The block SHALL be single-module, except for one sub-module signal_timeout (loadable down-counter with an expired flag).

Verification
REQ-037 Send 01, 5A in SDIdle -> key_code=5A, one key_valid pulse, back to SDIdle, no buff_wr.
REQ-038 Send 02, 11, 22, 33, 03 -> writes 11@0, 22@1, 33@2, byte_count=3, one stream_done pulse, overflow=0.
REQ-039 Send 02, 40 data bytes, 03 -> exactly 32 writes at addresses 0..31, byte_count=32, overflow=1, bytes 33..40 never written.
REQ-040 Send 02, 2 bytes, then idle TIMEOUT_CYCLES -> proto_err and stream_done pulse, byte_count=2, state SDIdle.
REQ-041 Send 7F in SDIdle -> proto_err pulse; then drop enable during SDKeyWait -> SDIdle, no key_valid.
REQ-042 Assert reset during a stream -> all outputs at reset values next cycle, no stream_done.

Source files
------------

// File: rtl/uart_signal_decoder_pkg.sv
// Shared UART definitions: receiver state enum, line constants and the
// signal decoder's state enum and control-byte codes.
package uart_signal_decoder_pkg;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    SDIdle    = 2'd0,
    SDKeyWait = 2'd1,
    SDStream  = 2'd2
  } sd_state_e;

  localparam logic [7:0] KEY_SIGNAL = 8'h01;
  localparam logic [7:0] BOS_SIGNAL = 8'h02;
  localparam logic [7:0] EOS_SIGNAL = 8'h03;

endpackage

// File: rtl/uart_signal_decoder_signal_timeout.sv
// Loadable down-counter; expired_o is high while counting is enabled and the
// count has run down to zero.
module signal_timeout #(
  parameter int unsigned CYCLES = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic load_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = CW'(CYCLES);
    end else if (count_en_i && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = count_en_i && (count_q == '0);

endmodule

// File: rtl/uart_signal_decoder.sv
// Decodes control bytes from a UART receiver into key codes and buffered
// data streams (BOS ... EOS), with an inter-byte timeout.
module uart_signal_decoder
  import uart_signal_decoder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_complete,
  output logic [7:0]            key_code,
  output logic                  key_valid,
  output logic                  buff_wr,
  output logic [ADDR_WIDTH-1:0] buff_addr,
  output logic [7:0]            buff_data,
  output logic                  stream_active,
  output logic                  stream_done,
  output logic [ADDR_WIDTH:0]   byte_count,
  output logic                  overflow,
  output logic                  proto_err,
  output logic [1:0]            dbg_state_o
);

  localparam logic [ADDR_WIDTH:0] BUF_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  sd_state_e             state_q, state_d;
  logic [7:0]            key_code_q, key_code_d;
  logic                  key_valid_q, key_valid_d;
  logic                  buff_wr_q, buff_wr_d;
  logic [ADDR_WIDTH-1:0] buff_addr_q, buff_addr_d;
  logic [7:0]            buff_data_q, buff_data_d;
  logic                  stream_active_q, stream_active_d;
  logic                  stream_done_q, stream_done_d;
  logic [ADDR_WIDTH:0]   byte_count_q, byte_count_d;
  logic                  overflow_q, overflow_d;
  logic                  proto_err_q, proto_err_d;

  logic                  counting, tmo_load, tmo_expired;
  logic                  wr_pending;
  logic [ADDR_WIDTH-1:0] addr_eff;
  logic [ADDR_WIDTH:0]   count_eff;

  // The counter only runs while waiting for a follow-up byte; it reloads
  // otherwise, so entering a waiting state always starts a full interval.
  assign counting = enable && (state_q != SDIdle);
  assign tmo_load = rx_complete || !counting;

  signal_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock      (clock),
    .reset      (reset),
    .load_i     (tmo_load),
    .count_en_i (counting),
    .expired_o  (tmo_expired)
  );

  // A write strobed last cycle has its address/count bump applied now, so a
  // back-to-back byte must see the post-increment values.
  assign wr_pending = !buff_wr_q;
  assign addr_eff   = buff_addr_q + ADDR_WIDTH'(wr_pending);
  assign count_eff  = byte_count_q + (ADDR_WIDTH + 1)'(wr_pending);

  always_comb begin
    state_d       = state_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    buff_wr_d     = 1'b1;
    buff_addr_d   = addr_eff;
    buff_data_d   = buff_data_q;
    byte_count_d  = count_eff;
    overflow_d    = overflow_q;
    stream_done_d = 1'b0;
    proto_err_d   = 1'b0;

    if (!enable) begin
      state_d = SDIdle;
    end else if (rx_complete) begin
      case (state_q)
        SDIdle: begin
          if (rx_byte == KEY_SIGNAL) begin
            state_d = SDKeyWait;
          end else if (rx_byte == BOS_SIGNAL) begin
            state_d      = SDStream;
            buff_addr_d  = '0;
            byte_count_d = '0;
            overflow_d   = 1'b0;
          end else begin
            proto_err_d = 1'b1;
          end
        end
        SDKeyWait: begin
          key_code_d  = rx_byte;
          key_valid_d = 1'b1;
          state_d     = SDIdle;
        end
        SDStream: begin
          if (rx_byte == EOS_SIGNAL) begin
            stream_done_d = 1'b1;
            state_d       = SDIdle;
          end else if (count_eff == BUF_DEPTH) begin
            overflow_d = 1'b1;
          end else begin
            buff_wr_d   = 1'b0;
            buff_data_d = rx_byte;
          end
        end
        default: state_d = SDIdle;
      endcase
    end else if (tmo_expired) begin
      proto_err_d   = 1'b1;
      stream_done_d = (state_q == SDStream);
      state_d       = SDIdle;
    end

    stream_active_d = (state_d == SDStream);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= SDIdle;
      key_code_q      <= '0;
      key_valid_q     <= 1'b0;
      buff_wr_q       <= 1'b1;
      buff_addr_q     <= '0;
      buff_data_q     <= '0;
      stream_active_q <= 1'b0;
      stream_done_q   <= 1'b0;
      byte_count_q    <= '0;
      overflow_q      <= 1'b0;
      proto_err_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      key_code_q      <= key_code_d;
      key_valid_q     <= key_valid_d;
      buff_wr_q       <= buff_wr_d;
      buff_addr_q     <= buff_addr_d;
      buff_data_q     <= buff_data_d;
      stream_active_q <= stream_active_d;
      stream_done_q   <= stream_done_d;
      byte_count_q    <= byte_count_d;
      overflow_q      <= overflow_d;
      proto_err_q     <= proto_err_d;
    end
  end

  assign key_code      = key_code_q;
  assign key_valid     = key_valid_q;
  assign buff_wr       = buff_wr_q;
  assign buff_addr     = buff_addr_q;
  assign buff_data     = buff_data_q;
  assign stream_active = stream_active_q;
  assign stream_done   = stream_done_q;
  assign byte_count    = byte_count_q;
  assign overflow      = overflow_q;
  assign proto_err     = proto_err_q;
  assign dbg_state_o   = state_q;

endmodule
